// File: rtl/parking_password_entry.sv
// Keypad front end: captures two 2-bit digits while a vehicle is at the entrance and
// presents them as a registered password pair. Optional attempt limit: PW_ATTEMPT_LIMIT_EN.
module parking_password_entry #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_ATTEMPTS   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_entrance,
    input  logic       key_valid,
    input  logic [1:0] key_code,
    input  logic       key_clear,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pw_ready,
    output logic [1:0] digit_count,
    output logic       entry_timeout,
    output logic       locked
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    generate
        if (TIMEOUT_CYCLES < 2 || MAX_ATTEMPTS < 1) begin : g_param_check
            $error("parking_password_entry: TIMEOUT_CYCLES must be >= 2 and MAX_ATTEMPTS >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_D1 = 3'd1,
        WAIT_D2 = 3'd2,
        HOLD    = 3'd3,
        TIMEOUT = 3'd4
`ifdef PW_ATTEMPT_LIMIT_EN
        ,
        LOCKOUT = 3'd5
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    d1_q, d1_d;
    logic [1:0]    d2_q, d2_d;
    logic          timer_done;

    assign timer_done = (timer_q == TW'(TIMEOUT_CYCLES - 1));

`ifdef PW_ATTEMPT_LIMIT_EN
    localparam int AW = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS) : 1;
    logic [AW-1:0] att_q, att_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        timer_d = timer_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
`ifdef PW_ATTEMPT_LIMIT_EN
        att_d   = att_q;
`endif
        if (!sensor_entrance) begin
            // Vehicle gone: abandon everything, including the attempt history.
            state_d = IDLE;
            timer_d = '0;
            d1_d    = '0;
            d2_d    = '0;
`ifdef PW_ATTEMPT_LIMIT_EN
            att_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_D1;
                    timer_d = '0;
                end
                WAIT_D1: begin
                    if (key_clear) begin
                        timer_d = '0;
                    end else if (key_valid) begin
                        d1_d    = key_code;
                        timer_d = '0;
                        state_d = WAIT_D2;
                    end else if (timer_done) begin
                        timer_d = '0;
                        state_d = TIMEOUT;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                WAIT_D2: begin
                    if (key_clear) begin
                        d1_d    = '0;
                        timer_d = '0;
                        state_d = WAIT_D1;
                    end else if (key_valid) begin
                        d2_d    = key_code;
                        timer_d = '0;
                        state_d = HOLD;
                    end else if (timer_done) begin
                        timer_d = '0;
                        state_d = TIMEOUT;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (key_clear) begin
                        d1_d    = '0;
                        d2_d    = '0;
                        timer_d = '0;
                        state_d = WAIT_D1;
`ifdef PW_ATTEMPT_LIMIT_EN
                        if (att_q == AW'(MAX_ATTEMPTS - 1)) state_d = LOCKOUT;
                        else                                att_d   = att_q + 1'b1;
`endif
                    end
                end
                TIMEOUT: begin
                    if (key_clear) begin
                        d1_d    = '0;
                        d2_d    = '0;
                        timer_d = '0;
                        state_d = WAIT_D1;
                    end
                end
`ifdef PW_ATTEMPT_LIMIT_EN
                LOCKOUT: state_d = LOCKOUT;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
    end

`ifdef PW_ATTEMPT_LIMIT_EN
    always_ff @(posedge clk) begin
        if (reset) att_q <= '0;
        else       att_q <= att_d;
    end

    always_ff @(posedge clk) begin
        if (reset) locked <= 1'b0;
        else       locked <= (state_q == LOCKOUT);
    end
`else
    assign locked = 1'b0;
`endif

    // Output register stage: the parking FSM sees glitch-free values decoded from state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            password_1    <= '0;
            password_2    <= '0;
            pw_ready      <= 1'b0;
            digit_count   <= '0;
            entry_timeout <= 1'b0;
        end else begin
            password_1    <= (state_q == HOLD) ? d1_q : 2'd0;
            password_2    <= (state_q == HOLD) ? d2_q : 2'd0;
            pw_ready      <= (state_q == HOLD);
            entry_timeout <= (state_q == TIMEOUT);
            case (state_q)
                WAIT_D2: digit_count <= 2'd1;
                HOLD:    digit_count <= 2'd2;
                default: digit_count <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_password_entry.sv
// Directed bench for parking_password_entry; follows PW_ATTEMPT_LIMIT_EN when defined.
module tb_parking_password_entry;

`ifdef PW_ATTEMPT_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_entrance;
    logic       key_valid;
    logic [1:0] key_code;
    logic       key_clear;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pw_ready;
    logic [1:0] digit_count;
    logic       entry_timeout;
    logic       locked;

    int n_checks = 0;
    int n_fail   = 0;

    parking_password_entry #(
        .TIMEOUT_CYCLES(16),
        .MAX_ATTEMPTS  (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sensor_entrance(sensor_entrance),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_clear      (key_clear),
        .password_1     (password_1),
        .password_2     (password_2),
        .pw_ready       (pw_ready),
        .digit_count    (digit_count),
        .entry_timeout  (entry_timeout),
        .locked         (locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [1:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        key_code  = 2'd0;
    endtask

    task automatic clear_pulse();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
    endtask

    task automatic rearm();
        sensor_entrance = 1'b0;
        tick();
        sensor_entrance = 1'b1;
        tick();
    endtask

    task automatic check_password(input string tag, input logic [1:0] p1, input logic [1:0] p2,
                                  input logic rdy);
        check({tag, "_p1"}, {2'b0, password_1}, {2'b0, p1});
        check({tag, "_p2"}, {2'b0, password_2}, {2'b0, p2});
        check({tag, "_rdy"}, {3'b0, pw_ready}, {3'b0, rdy});
    endtask

    initial begin
        reset           = 1'b1;
        sensor_entrance = 1'b1;
        key_valid       = 1'b0;
        key_code        = 2'd0;
        key_clear       = 1'b0;
        repeat (3) tick();

        // Reset state with sensor held high
        check_password("rst", 2'd0, 2'd0, 1'b0);
        check("rst_cnt", {2'b0, digit_count}, 4'd0);
        check("rst_to", {3'b0, entry_timeout}, 4'd0);
        check("rst_lock", {3'b0, locked}, 4'd0);

        // Release reset, enter 1 then 2
        reset = 1'b0;
        tick();
        press(2'd1);
        press(2'd2);
        check("d2_edge_cnt", {2'b0, digit_count}, 4'd1);
        check("d2_edge_rdy", {3'b0, pw_ready}, 4'd0);
        tick();
        check_password("hold", 2'd1, 2'd2, 1'b1);
        check("hold_cnt", {2'b0, digit_count}, 4'd2);
        repeat (5) tick();
        press(2'd3);
        tick();
        check_password("hold_stable", 2'd1, 2'd2, 1'b1);

        // Drop sensor while holding
        sensor_entrance = 1'b0;
        tick();
        tick();
        check_password("drop", 2'd0, 2'd0, 1'b0);
        check("drop_cnt", {2'b0, digit_count}, 4'd0);
        press(2'd2);
        press(2'd1);
        tick();
        check_password("idle_keys", 2'd0, 2'd0, 1'b0);
        check("idle_cnt", {2'b0, digit_count}, 4'd0);

        // Timeout after one digit: key at E0, 16 silent edges, output follows one edge later
        sensor_entrance = 1'b1;
        tick();
        press(2'd3);
        repeat (16) tick();
        check("to_early", {3'b0, entry_timeout}, 4'd0);
        tick();
        check("to_set", {3'b0, entry_timeout}, 4'd1);
        check_password("to_pw", 2'd0, 2'd0, 1'b0);
        press(2'd1);
        tick();
        check("to_key_ignored", {3'b0, entry_timeout}, 4'd1);
        clear_pulse();
        tick();
        check("to_clr", {3'b0, entry_timeout}, 4'd0);
        check("to_clr_cnt", {2'b0, digit_count}, 4'd0);
        press(2'd0);
        press(2'd3);
        tick();
        check_password("to_retry", 2'd0, 2'd3, 1'b1);

        // Simultaneous key and clear in WAIT_D2: clear wins
        rearm();
        press(2'd1);
        key_valid = 1'b1;
        key_code  = 2'd2;
        key_clear = 1'b1;
        tick();
        key_valid = 1'b0;
        key_clear = 1'b0;
        tick();
        check("sim_cnt", {2'b0, digit_count}, 4'd0);
        check("sim_rdy", {3'b0, pw_ready}, 4'd0);
        press(2'd2);
        press(2'd1);
        tick();
        check_password("sim_retry", 2'd2, 2'd1, 1'b1);

        // Attempt limit: three submit/clear rounds
        rearm();
        for (int i = 0; i < 3; i++) begin
            press(2'd1);
            press(2'd1);
            tick();
            check_password("att_round", 2'd1, 2'd1, 1'b1);
            clear_pulse();
            tick();
        end
        check("att_lock", {3'b0, locked}, {3'b0, LIMIT});
        check("att_rdy", {3'b0, pw_ready}, 4'd0);
        press(2'd1);
        press(2'd1);
        tick();
        check("att_keys_rdy", {3'b0, pw_ready}, {3'b0, !LIMIT});
        check("att_keys_lock", {3'b0, locked}, {3'b0, LIMIT});
        sensor_entrance = 1'b0;
        tick();
        tick();
        check("att_unlock", {3'b0, locked}, 4'd0);

        // Reset while holding a password
        sensor_entrance = 1'b1;
        tick();
        press(2'd2);
        press(2'd3);
        tick();
        check_password("pre_rst", 2'd2, 2'd3, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_password("mid_rst", 2'd0, 2'd0, 1'b0);
        check("mid_rst_cnt", {2'b0, digit_count}, 4'd0);
        tick();
        press(2'd1);
        tick();
        check("rearm_cnt", {2'b0, digit_count}, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
